branch_sequencer: RTL

// - Control-side consumer of the CON flip-flop: sequences the T3..T6 steps of a conditional branch (brzr/brnz/brpl/brmi).
// - Strobes CONin to evaluate the condition, then, on the registered CON value, either skips or drives PC <= PC + C_sign_extended.
// - Sits in the control unit beside the datapath; takes over from fetch/decode via a start/done handshake.

---
 rtl/branch_sequencer_pkg.sv | 38 +++
 rtl/branch_sequencer_if.sv | 44 ++++
 rtl/branch_stats.sv | 50 +++++
 rtl/branch_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/branch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer_pkg
// Purpose  : Shared definitions for the conditional-branch sequencer. It holds
//            the step encoding (IDLE, T3..T6, FIN), the branch opcode and the
//            condition-field codes used by decode logic and by the bench.
// Revision : 1.0 - initial release
// ============================================================================
package branch_sequencer_pkg;

    // Width of the ir[31:27] opcode field.
    localparam int          c_opcode_w = 5;
    // Opcode of the conditional branch family (brzr/brnz/brpl/brmi).
    localparam logic [4:0]  c_br_opcode = 5'b10010;

    // Condition codes carried in the C2 field (ir[20:19]).
    localparam logic [1:0]  c_cond_zero    = 2'b00;
    localparam logic [1:0]  c_cond_nonzero = 2'b01;
    localparam logic [1:0]  c_cond_pos     = 2'b10;
    localparam logic [1:0]  c_cond_neg     = 2'b11;

    // Sequencer steps.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // Extracts the condition field of a branch instruction.
    function automatic logic [1:0] cond_field(input logic [31:0] ir);
        return ir[20:19];
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer_if
// Purpose  : Bundle between fetch/decode + datapath (master) and the branch
//            sequencer (slave).
//            master -> slave : start, ir[31:0], con_ff
//            slave -> master : gra, r_out, con_in, pc_out, y_in, c_out,
//                              alu_add, z_in, zlo_out, pc_in, busy, done,
//                              taken, err
// Revision : 1.0 - initial release
// ============================================================================
interface branch_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        con_ff;

    logic        gra;
    logic        r_out;
    logic        con_in;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic        alu_add;
    logic        z_in;
    logic        zlo_out;
    logic        pc_in;
    logic        busy;
    logic        done;
    logic        taken;
    logic        err;

    modport master (
        output start, ir, con_ff,
        input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
               zlo_out, pc_in, busy, done, taken, err
    );

    modport slave (
        input  start, ir, con_ff,
        output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
               zlo_out, pc_in, busy, done, taken, err
    );
endinterface
`default_nettype wire

// File: rtl/branch_stats.sv
`default_nettype none
// ============================================================================
// Module   : branch_stats
// Purpose  : Two saturating outcome counters for completed legal branches.
// Ports    : clk, clr (async, active-high)
//            inc_taken_i / inc_not_taken_i : one-cycle increment requests
//            stat_taken_o / stat_not_taken_o : counter values [STAT_W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module branch_stats #(
    parameter int STAT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              clr,
    input  wire logic              inc_taken_i,
    input  wire logic              inc_not_taken_i,
    output logic [STAT_W-1:0]      stat_taken_o,
    output logic [STAT_W-1:0]      stat_not_taken_o
);

    logic [STAT_W-1:0] taken_q, taken_d;
    logic [STAT_W-1:0] not_taken_q, not_taken_d;

    // Counters hold at all-ones rather than wrapping.
    always_comb begin
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        if (inc_taken_i && !(&taken_q)) begin
            taken_d = taken_q + 1'b1;
        end
        if (inc_not_taken_i && !(&not_taken_q)) begin
            not_taken_d = not_taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

    assign stat_taken_o     = taken_q;
    assign stat_not_taken_o = not_taken_q;

endmodule
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_sequencer
// Purpose  : Sequences the T3..T6 control steps of a conditional branch.
//            T3 loads the CON flip-flop, T4 reads it back and either skips to
//            FIN or continues with PC <= PC + sign_extend(C) over T4..T6.
//            FIN reports done/taken/err for one cycle.
// Ports    : clk           rising-edge clock
//            clr           asynchronous active-high reset
//            bus (slave)   start/ir/con_ff in; strobes, busy, done, taken,
//                          err out
//            stat_taken_o, stat_not_taken_o [STAT_W-1:0]
//                          outcome counters, present only when the macro
//                          BRANCH_STATS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int                  OPCODE_W  = c_opcode_w,
    parameter logic [OPCODE_W-1:0] BR_OPCODE = c_br_opcode,
    parameter int                  STAT_W    = 16
) (
    input  wire logic            clk,
    input  wire logic            clr,
    branch_sequencer_if.slave    bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_taken_o,
    output logic [STAT_W-1:0]    stat_not_taken_o
`endif
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    // Set when FIN is entered from T6; read only while in FIN.
    logic                taken_q, taken_d;
    logic                fin_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            taken_q  <= taken_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        taken_d  = taken_q;
        unique case (state_q)
            S_IDLE: begin
                taken_d = 1'b0;
                if (bus.start) begin
                    opcode_d = bus.ir[31 -: OPCODE_W];
                    // Illegal opcodes go straight to FIN without strobes.
                    state_d  = (bus.ir[31 -: OPCODE_W] == BR_OPCODE) ? S_T3 : S_FIN;
                end
            end
            S_T3: state_d = S_T4;
            // The only place con_ff is consulted; it was loaded at the T3 edge.
            S_T4: state_d = bus.con_ff ? S_T5 : S_FIN;
            S_T5: state_d = S_T6;
            S_T6: begin
                state_d = S_FIN;
                taken_d = 1'b1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore, except the T4 group which is gated by con_ff)
    // ------------------------------------------------------------------
    assign fin_err = (opcode_q != BR_OPCODE);

    always_comb begin
        bus.gra     = 1'b0;
        bus.r_out   = 1'b0;
        bus.con_in  = 1'b0;
        bus.pc_out  = 1'b0;
        bus.y_in    = 1'b0;
        bus.c_out   = 1'b0;
        bus.alu_add = 1'b0;
        bus.z_in    = 1'b0;
        bus.zlo_out = 1'b0;
        bus.pc_in   = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.taken   = 1'b0;
        bus.err     = 1'b0;
        unique case (state_q)
            S_T3: begin
                bus.gra    = 1'b1;
                bus.r_out  = 1'b1;
                bus.con_in = 1'b1;
                bus.busy   = 1'b1;
            end
            S_T4: begin
                bus.pc_out = bus.con_ff;
                bus.y_in   = bus.con_ff;
                bus.busy   = 1'b1;
            end
            S_T5: begin
                bus.c_out   = 1'b1;
                bus.alu_add = 1'b1;
                bus.z_in    = 1'b1;
                bus.busy    = 1'b1;
            end
            S_T6: begin
                bus.zlo_out = 1'b1;
                bus.pc_in   = 1'b1;
                bus.busy    = 1'b1;
            end
            S_FIN: begin
                bus.done  = 1'b1;
                bus.taken = taken_q;
                bus.err   = fin_err;
            end
            default: ;
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic inc_taken;
    logic inc_not_taken;

    // Error completions are counted by neither counter.
    assign inc_taken     = (state_q == S_FIN) && !fin_err &&  taken_q;
    assign inc_not_taken = (state_q == S_FIN) && !fin_err && !taken_q;

    branch_stats #(
        .STAT_W (STAT_W)
    ) u_branch_stats (
        .clk              (clk),
        .clr              (clr),
        .inc_taken_i      (inc_taken),
        .inc_not_taken_i  (inc_not_taken),
        .stat_taken_o     (stat_taken_o),
        .stat_not_taken_o (stat_not_taken_o)
    );
`endif

endmodule
`default_nettype wire
